// File: rtl/bf16_result_checker.sv
// Streaming checker for bfloat16 MAC results: expected values are queued in a FIFO,
// DUT results are compared in order, and counts, first failure and a MISR signature are kept.
module bf16_result_checker #(
   parameter int BIT_WIDTH  = 16,
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 7,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 32,
   parameter int NAN_EQUIV  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] num_vectors,
   input  logic                 exp_valid,
   output logic                 exp_ready,
   input  logic [BIT_WIDTH-1:0] exp_data,
   input  logic                 res_valid,
   output logic                 res_ready,
   input  logic [BIT_WIDTH-1:0] res_data,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] checked_cnt,
   output logic [CNT_WIDTH-1:0] mismatch_cnt,
   output logic [CNT_WIDTH-1:0] first_fail_idx,
   output logic [BIT_WIDTH-1:0] first_fail_got,
   output logic [BIT_WIDTH-1:0] first_fail_exp,
   output logic [BIT_WIDTH-1:0] signature,
   output logic                 underrun
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [BIT_WIDTH-1:0] MISR_POLY = BIT_WIDTH'(16'h1021);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [PTR_W:0]       count;
   logic [CNT_WIDTH-1:0] target;

   logic                 full, empty, start_acc, push, res_fire, pop, match;
   logic [BIT_WIDTH-1:0] head, sig_next;

   function automatic logic is_nan(input logic [BIT_WIDTH-1:0] v);
      return (&v[MANT_WIDTH +: EXP_WIDTH]) && (|v[MANT_WIDTH-1:0]);
   endfunction

   assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign start_acc = start && (state != RUN);
   assign exp_ready = busy && !full;
   assign res_ready = busy;
   assign push      = exp_valid && exp_ready;
   assign res_fire  = res_valid && res_ready;
   // Pop uses the registered count, so a same-cycle push into an empty FIFO is not seen.
   assign pop       = res_fire && !empty;
   assign head      = mem[rd_ptr];
   assign match     = (head == res_data) ||
                      ((NAN_EQUIV != 0) && is_nan(head) && is_nan(res_data));
   assign sig_next  = {signature[BIT_WIDTH-2:0], 1'b0} ^
                      (signature[BIT_WIDTH-1] ? MISR_POLY : '0) ^ res_data;

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (checked_cnt == target) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= exp_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (start_acc) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target         <= '0;
         checked_cnt    <= '0;
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
         first_fail_got <= '0;
         first_fail_exp <= '0;
         signature      <= '0;
         underrun       <= 1'b0;
      end else if (start_acc) begin
         target         <= num_vectors;
         checked_cnt    <= '0;
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
         first_fail_got <= '0;
         first_fail_exp <= '0;
         signature      <= '1;
         underrun       <= 1'b0;
      end else if (res_fire) begin
         signature <= sig_next;
         if (empty) begin
            underrun <= 1'b1;
         end else begin
            if (checked_cnt != '1) checked_cnt <= checked_cnt + CNT_WIDTH'(1);
            if (!match) begin
               // Saturated counters never return to zero, so zero marks "no failure yet".
               if (mismatch_cnt == '0) begin
                  first_fail_idx <= checked_cnt;
                  first_fail_got <= res_data;
                  first_fail_exp <= head;
               end
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule
